// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative radix-2 multiply / restoring divide sequencer owning HI/LO
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   bmag_q;
    logic [CW-1:0]      count_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               is_div_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH:0]   mul_next_d;
    logic [2*WIDTH:0]   shifted_d;
    logic [WIDTH:0]     trial_d;
    logic [2*WIDTH:0]   div_next_d;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    always_comb begin
        a_mag_d = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag_d = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

        // Multiply: the multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum_d  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
        mul_next_d = {1'b0, mul_sum_d, acc_q[WIDTH-1:1]};

        // Divide: remainder in the upper W+1 bits so the trial subtract can borrow.
        shifted_d  = {acc_q[2*WIDTH-1:0], 1'b0};
        trial_d    = shifted_d[2*WIDTH:WIDTH] - {1'b0, bmag_q};
        div_next_d = trial_d[WIDTH] ? shifted_d
                                    : {trial_d, shifted_d[WIDTH-1:1], 1'b1};

        acc_d = is_div_q ? div_next_d : mul_next_d;

        prod_d = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo_d  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_d   = is_div_q ? rem_d : prod_d[2*WIDTH-1:WIDTH];
        lo_d   = is_div_q ? quo_d : prod_d[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            bmag_q     <= '0;
            count_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        div_zero_q <= 1'b0;
                        is_div_q   <= op[1];
                        neg_res_q  <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem_q  <= op[0] & src_a[WIDTH-1];
                        acc_q      <= {{(WIDTH+1){1'b0}}, a_mag_d};
                        bmag_q     <= b_mag_d;
                        count_q    <= CW'(WIDTH - 1);
                        if (op[1] && (src_b == '0)) begin
                            hi_q       <= src_a;
                            lo_q       <= '1;
                            div_zero_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == '0) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign stall    = busy & (start | hilo_rd);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_rd;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hilo_rd(hilo_rd), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE and returns in the DONE cycle; lat = edges until done, -1 on timeout.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        op = o; src_a = a; src_b = b; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; hilo_rd = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu();
        int lat;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        total++; if (lat != 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", hi, lo); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL done_busy got=%b exp=1", busy); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b/%b exp=0/0", done, busy); end
    endtask

    task automatic test_mult();
        int lat;
        issue(MULT, 32'hFFFF_FFF9, 32'd3, lat); tick();
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_m7x3 got=%h/%h exp=ffffffff/ffffffeb", hi, lo); end
        issue(MULT, 32'h8000_0000, 32'h8000_0000, lat); tick();
        total++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin bad++; $display("FAIL mult_minsq got=%h/%h exp=40000000/00000000", hi, lo); end
    endtask

    task automatic test_div();
        int lat;
        issue(DIV, 32'hFFFF_FFF9, 32'd2, lat); tick();
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7d2 got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        issue(DIV, 32'd7, 32'hFFFF_FFFE, lat); tick();
        total++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7dm2 got=%h/%h exp=00000001/fffffffd", hi, lo); end
        issue(DIVU, 32'd100, 32'd7, lat); tick();
        total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL divu_100d7 got=%h/%h exp=2/e", hi, lo); end
        total++; if (lat != 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat); tick();
        total++; if (hi !== 32'h0 || lo !== 32'h8000_0000 || div_zero !== 1'b0) begin bad++; $display("FAIL div_ovf got=%h/%h/%b exp=0/80000000/0", hi, lo, div_zero); end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(DIVU, 32'd5, 32'd0, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        total++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin bad++; $display("FAIL dz_result got=%h/%h/%b exp=5/ffffffff/1", hi, lo, div_zero); end
        tick();
        issue(DIVU, 32'd8, 32'd2, lat); tick();
        total++; if (div_zero !== 1'b0 || lo !== 32'd4 || hi !== 32'd0) begin bad++; $display("FAIL dz_clear got=%b/%h/%h exp=0/4/0", div_zero, lo, hi); end
    endtask

    task automatic test_stall();
        logic [31:0] old_hi, old_lo;
        int lat;
        old_hi = hi; old_lo = lo;
        op = MULTU; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        hilo_rd = 1'b1; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_rd got=%b exp=1", stall); end
        total++; if (hi !== old_hi || lo !== old_lo) begin bad++; $display("FAIL hold_hilo got=%h/%h exp=%h/%h", hi, lo, old_hi, old_lo); end
        hilo_rd = 1'b0;
        op = DIVU; src_a = 32'd9; src_b = 32'd3; start = 1'b1; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_start got=%b exp=1", stall); end
        tick(); tick();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin lat = i; break; end
            tick();
        end
        total++; if (lat < 0) begin bad++; $display("FAIL stall_timeout got=%0d exp=>=0", lat); end
        total++; if (hi !== 32'd0 || lo !== 32'd42) begin bad++; $display("FAIL stall_result got=%h/%h exp=0/2a", hi, lo); end
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL second_start got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(MULTU, 32'd10, 32'd10, lat);
        hilo_rd = 1'b1; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", stall); end
        tick();
        op = MULTU; src_a = 32'd2; src_b = 32'd3; start = 1'b1; #1;
        total++; if (stall !== 1'b0 || lo !== 32'd100) begin bad++; $display("FAIL idle_rd_start got=%b/%h exp=0/64", stall, lo); end
        hilo_rd = 1'b0;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || lo !== 32'd100) begin bad++; $display("FAIL accepted got=%b/%h exp=1/64", busy, lo); end
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin lat = i; break; end
            tick();
        end
        total++; if (lo !== 32'd6 || lat != 33) begin bad++; $display("FAIL b2b_result got=%h/%0d exp=6/33", lo, lat); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        op = MULTU; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0; #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%h/%h/%b exp=0/0/0/0", busy, hi, lo, done); end
        tick();
        rst_n = 1'b1;
        tick();
        issue(MULTU, 32'd3, 32'd4, lat);
        total++; if (lo !== 32'd12 || hi !== 32'd0 || lat != 34) begin bad++; $display("FAIL after_reset got=%h/%h/%0d exp=c/0/34", lo, hi, lat); end
        tick();
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
